rr_arbiter_merge: RTL

// - Clocked N-way round-robin arbiter and merge. Replaces the fixed 2-input arbiter.
// - N requesters each offer a WIDTH-bit token on a valid/ready channel.
// - One winner per cycle is forwarded, with its index, into a single registered output slot.
// - Sits in front of shared resources (router output port, shared PE, memory port).
// - Gives fair, starvation-free access with deterministic cycle timing.

---
 rtl/rr_arbiter_merge.sv | 110 +++++++++++
 1 files changed

// File: rtl/rr_arbiter_merge.sv
// rr_arbiter_merge
//   Clocked N-way round-robin arbiter and merge. Each of NUM_REQ requesters
//   offers a WIDTH-bit token on a valid/ready channel. At most one winner per
//   cycle is forwarded, together with its index, into a single registered
//   output slot. The priority pointer moves to the requester after the last
//   winner, so every continuously valid requester is served within NUM_REQ
//   grants.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (synchronous release expected)
//   req_valid    [NUM_REQ]        requester i offers a token
//   req_data     [NUM_REQ*WIDTH]  requester i token at [i*WIDTH +: WIDTH]
//   req_ready    [NUM_REQ]        one-hot (or zero) grant, token taken this cycle
//   out_valid    output slot holds a token
//   out_ready    consumer takes the token this cycle
//   out_data     [WIDTH]          winning token
//   out_sel      [SEL_W]          index of the winning requester
//   conflict_cnt [16]             only with ARB_STATS_EN: saturating count of
//                                 grants made while two or more requests were valid
//
// Configuration macro: ARB_STATS_EN (adds conflict_cnt port and counter).

module rr_arbiter_merge #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]              conflict_cnt
`endif
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             accept;
  logic             grant;

  assign accept = !out_valid || out_ready;

  // Scan ptr, ptr+1, ... with wrap-around; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [SEL_W:0]   idx_w;
      logic [SEL_W-1:0] idx;
      idx_w = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx_w >= (SEL_W+1)'(NUM_REQ))
        idx_w = idx_w - (SEL_W+1)'(NUM_REQ);
      idx = idx_w[SEL_W-1:0];
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        win_idx  = idx;
        win_data = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with reset keeps req_ready low while the slot is held in reset,
  // even though accept is already true there.
  assign grant     = found && accept && !reset;
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign ptr_nxt   = (win_idx == SEL_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_sel   <= win_idx;
      ptr       <= ptr_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  logic multi_req;

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign multi_req = |(req_valid & (req_valid - 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if (grant && multi_req && conflict_cnt != '1)
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif

endmodule
